// File: rtl/titan_lsu_pkg.sv
// Shared definitions for the titan MEM/LSU stage: trap causes, FSM states, flag bit positions.
package titan_lsu_pkg;

  localparam logic [3:0] EXC_LD_MIS = 4'd4;
  localparam logic [3:0] EXC_LD_FLT = 4'd5;
  localparam logic [3:0] EXC_ST_MIS = 4'd6;
  localparam logic [3:0] EXC_ST_FLT = 4'd7;

  localparam int unsigned FLG_WRITE = 5;
  localparam int unsigned FLG_READ  = 4;
  localparam int unsigned FLG_WORD  = 3;
  localparam int unsigned FLG_HALF  = 2;
  localparam int unsigned FLG_BYTE  = 1;
  localparam int unsigned FLG_UNS   = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/titan_lsu_if.sv
// Data-bus handshake between the LSU (master) and memory (slave).
interface titan_lsu_if;
  logic [31:0] addr;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic        stb;
  logic        ack;
  logic        err;

  modport master (output addr, dat_w, sel, we, cyc, stb, input dat_r, ack, err);
  modport slave  (input addr, dat_w, sel, we, cyc, stb, output dat_r, ack, err);
endinterface

// File: rtl/titan_lsu_align.sv
// Byte-lane steering for stores and lane extract plus sign/zero extension for loads.
module titan_lsu_align (
  input  logic [1:0]  i_off,
  input  logic        i_word,
  input  logic        i_half,
  input  logic        i_byte,
  input  logic        i_uns,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_sel,
  output logic [31:0] o_wdat,
  output logic [31:0] o_ldata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    o_sel   = '0;
    o_wdat  = i_wdata;
    o_ldata = i_rdata;
    w_byte  = i_rdata[{i_off, 3'b000} +: 8];
    w_half  = i_rdata[{i_off[1], 4'b0000} +: 16];
    if (i_word) begin
      o_sel = '1;
    end else if (i_half) begin
      o_sel   = i_off[1] ? 4'b1100 : 4'b0011;
      o_wdat  = {2{i_wdata[15:0]}};
      o_ldata = i_uns ? {16'h0000, w_half} : {{16{w_half[15]}}, w_half};
    end else if (i_byte) begin
      o_sel   = 4'b0001 << i_off;
      o_wdat  = {4{i_wdata[7:0]}};
      o_ldata = i_uns ? {24'h000000, w_byte} : {{24{w_byte[7]}}, w_byte};
    end
  end

endmodule

// File: rtl/titan_lsu_stage.sv
// MEM pipeline stage: drives the data bus, stalls while a cycle is outstanding,
// raises misaligned/fault traps and registers results into WB.
module titan_lsu_stage
  import titan_lsu_pkg::*;
#(
  parameter int unsigned SIDE_W    = 53,
  parameter int unsigned TIMEOUT   = 16,
  parameter logic [31:0] NOP_INSTR = 32'h33
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wb_stall_i,
  input  logic              wb_flush_i,
  output logic              mem_stall_o,
  output logic [31:0]       forward_mem_dat_o,
  input  logic [31:0]       mem_pc_i,
  input  logic [31:0]       mem_instruction_i,
  input  logic [31:0]       mem_result_i,
  input  logic [31:0]       mem_wdata_i,
  input  logic [4:0]        mem_waddr_i,
  input  logic              mem_we_i,
  input  logic [5:0]        mem_mem_flags_i,
  input  logic [3:0]        mem_exception_i,
  input  logic [31:0]       mem_exc_data_i,
  input  logic              mem_trap_valid_i,
  input  logic [SIDE_W-1:0] mem_side_i,
  titan_lsu_if.master       dbus,
  output logic [31:0]       wb_pc_o,
  output logic [31:0]       wb_instruction_o,
  output logic [31:0]       wb_result_o,
  output logic [31:0]       wb_exc_data_o,
  output logic [4:0]        wb_waddr_o,
  output logic              wb_we_o,
  output logic [3:0]        wb_exception_o,
  output logic              wb_trap_valid_o,
  output logic [SIDE_W-1:0] wb_side_o
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  lsu_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_drop;
  logic             r_fault;
  logic [31:0]      r_rdata;

  logic        w_rd, w_wr, w_access, w_is_ld, w_is_st, w_mis, w_start;
  logic        w_tmo, w_bus_end, w_stall, w_trap, w_we;
  logic [3:0]  w_sel, w_exc;
  logic [31:0] w_sdat, w_ldata, w_res, w_exc_data;

  assign w_rd     = mem_mem_flags_i[FLG_READ];
  assign w_wr     = mem_mem_flags_i[FLG_WRITE];
  assign w_access = (w_rd | w_wr) & ~mem_trap_valid_i;
  assign w_is_ld  = w_access & w_rd;
  assign w_is_st  = w_access & ~w_rd;
  assign w_mis    = w_access &
                    ((mem_mem_flags_i[FLG_WORD] & (mem_result_i[1:0] != 2'b00)) |
                     (~mem_mem_flags_i[FLG_WORD] & mem_mem_flags_i[FLG_HALF] & mem_result_i[0]));
  assign w_start  = w_access & ~w_mis;

  assign w_tmo     = (TIMEOUT != 0) && (r_cnt == TMO_LAST);
  assign w_bus_end = dbus.ack | dbus.err | w_tmo;
  assign w_stall   = ((r_state == ST_IDLE) && w_start) || (r_state == ST_BUSY);
  assign mem_stall_o = w_stall;

  titan_lsu_align u_align (
    .i_off   (mem_result_i[1:0]),
    .i_word  (mem_mem_flags_i[FLG_WORD]),
    .i_half  (mem_mem_flags_i[FLG_HALF]),
    .i_byte  (mem_mem_flags_i[FLG_BYTE]),
    .i_uns   (mem_mem_flags_i[FLG_UNS]),
    .i_wdata (mem_wdata_i),
    .i_rdata (r_rdata),
    .o_sel   (w_sel),
    .o_wdat  (w_sdat),
    .o_ldata (w_ldata)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_drop     <= 1'b0;
      r_fault    <= 1'b0;
      r_rdata    <= '0;
      dbus.addr  <= '0;
      dbus.dat_w <= '0;
      dbus.sel   <= '0;
      dbus.we    <= 1'b0;
      dbus.cyc   <= 1'b0;
      dbus.stb   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state    <= ST_BUSY;
            r_cnt      <= '0;
            r_drop     <= 1'b0;
            r_fault    <= 1'b0;
            dbus.addr  <= {mem_result_i[31:2], 2'b00};
            dbus.dat_w <= w_sdat;
            dbus.sel   <= w_sel;
            dbus.we    <= w_is_st;
            dbus.cyc   <= 1'b1;
            dbus.stb   <= 1'b1;
          end
        end
        ST_BUSY: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (wb_flush_i) r_drop <= 1'b1;
          if (w_bus_end) begin
            dbus.cyc <= 1'b0;
            dbus.stb <= 1'b0;
            r_fault  <= ~dbus.ack;
            if (dbus.ack) r_rdata <= dbus.dat_r;
            // A flushed access still completes on the bus but never reaches WB.
            r_state  <= (r_drop || wb_flush_i) ? ST_IDLE : ST_DONE;
          end
        end
        ST_DONE: begin
          if (wb_flush_i || !wb_stall_i) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_trap     = 1'b0;
    w_exc      = mem_exception_i;
    w_exc_data = mem_exc_data_i;
    if (mem_trap_valid_i) begin
      w_trap = 1'b1;
    end else if (w_mis && w_is_ld) begin
      w_trap = 1'b1; w_exc = EXC_LD_MIS; w_exc_data = mem_result_i;
    end else if (w_mis && w_is_st) begin
      w_trap = 1'b1; w_exc = EXC_ST_MIS; w_exc_data = mem_result_i;
    end else if ((r_state == ST_DONE) && r_fault && w_is_ld) begin
      w_trap = 1'b1; w_exc = EXC_LD_FLT; w_exc_data = mem_result_i;
    end else if ((r_state == ST_DONE) && r_fault && w_is_st) begin
      w_trap = 1'b1; w_exc = EXC_ST_FLT; w_exc_data = mem_result_i;
    end
  end

  assign w_res = ((r_state == ST_DONE) && w_is_ld && !r_fault) ? w_ldata : mem_result_i;
  assign w_we  = mem_we_i & ~w_trap;
  assign forward_mem_dat_o = w_res;

  // While the stage stalls, WB takes a bubble so the instruction retires exactly once (from DONE).
  always_ff @(posedge clk_i) begin
    if (rst_i || wb_flush_i || (!wb_stall_i && w_stall)) begin
      wb_pc_o          <= '0;
      wb_instruction_o <= NOP_INSTR;
      wb_result_o      <= '0;
      wb_exc_data_o    <= '0;
      wb_waddr_o       <= '0;
      wb_we_o          <= 1'b0;
      wb_exception_o   <= '0;
      wb_trap_valid_o  <= 1'b0;
      wb_side_o        <= '0;
    end else if (!wb_stall_i) begin
      wb_pc_o          <= mem_pc_i;
      wb_instruction_o <= mem_instruction_i;
      wb_result_o      <= w_res;
      wb_exc_data_o    <= w_exc_data;
      wb_waddr_o       <= mem_waddr_i;
      wb_we_o          <= w_we;
      wb_exception_o   <= w_exc;
      wb_trap_valid_o  <= w_trap;
      wb_side_o        <= mem_side_i;
    end
  end

endmodule
